// File: rtl/merge.sv
// merge: gathers KERNEL_LENGTH-wide parallel columns (lane k = kernel row k)
// into a ping-pong pair of banks and re-serializes each full bank as
// KERNEL_LENGTH row-major bursts of BURST_LENGTH words.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - asynchronous active-low reset
//   din_valid  - input column valid
//   din_ready  - a column can be accepted this cycle
//   din        - input column, lane k = row k
//   dout_valid - output word valid
//   dout_ready - sink accepts output word
//   dout       - serialized output word
//   dout_last  - last word of the current row burst
//   dout_row   - row index of the current output word
//   full_flag  - both banks FULL
//   empty_flag - both banks FREE and no partially filled bank
module merge #(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LENGTH  = 32,
    parameter int KERNEL_LENGTH = 3,
    localparam int ROW_W = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     din_valid,
    output logic                                     din_ready,
    input  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] din,
    output logic                                     dout_valid,
    input  logic                                     dout_ready,
    output logic [DATA_WIDTH-1:0]                    dout,
    output logic                                     dout_last,
    output logic [ROW_W-1:0]                         dout_row,
    output logic                                     full_flag,
    output logic                                     empty_flag
);

    localparam int COL_W = $clog2(BURST_LENGTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BURST_LENGTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KERNEL_LENGTH - 1);

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_e;

    bank_e            bank_q [2];
    bank_e            bank_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic [COL_W-1:0] wr_col_q,  wr_col_d;
    logic             rd_bank_q, rd_bank_d;
    logic [ROW_W-1:0] rd_row_q,  rd_row_d;
    logic [COL_W-1:0] rd_col_q,  rd_col_d;

    logic [DATA_WIDTH-1:0] mem_q [2][KERNEL_LENGTH][BURST_LENGTH];

    logic wr_fire;
    logic rd_fire;

    always_comb begin
        din_ready  = (bank_q[wr_bank_q] == FREE);
        dout_valid = (bank_q[rd_bank_q] == FULL);
        dout       = dout_valid ? mem_q[rd_bank_q][rd_row_q][rd_col_q] : '0;
        dout_row   = rd_row_q;
        dout_last  = dout_valid && (rd_col_q == COL_LAST);
        full_flag  = (bank_q[0] == FULL) && (bank_q[1] == FULL);
        empty_flag = (bank_q[0] == FREE) && (bank_q[1] == FREE) && (wr_col_q == '0);
        wr_fire    = din_valid && din_ready;
        rd_fire    = dout_valid && dout_ready;
    end

    // Fill and drain always address different banks (write needs FREE, read
    // needs FULL), so both bank-state updates can land on the same edge.
    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        wr_col_d  = wr_col_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;

        if (wr_fire) begin
            if (wr_col_q == COL_LAST) begin
                bank_d[wr_bank_q] = FULL;
                wr_col_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rd_col_q == COL_LAST) begin
                rd_col_d = '0;
                if (rd_row_q == ROW_LAST) begin
                    bank_d[rd_bank_q] = FREE;
                    rd_row_d          = '0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    rd_row_d = rd_row_q + 1'b1;
                end
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q[0] <= FREE;
            bank_q[1] <= FREE;
            wr_bank_q <= 1'b0;
            wr_col_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank_q <= wr_bank_d;
            wr_col_q  <= wr_col_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Storage is deliberately not reset; bank state alone gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned k = 0; k < KERNEL_LENGTH; k++) begin
                mem_q[wr_bank_q][k][wr_col_q] <= din[k];
            end
        end
    end

endmodule

// File: tb/tb_merge.sv
// tb_merge: directed self-checking bench for merge with KERNEL_LENGTH=3,
// BURST_LENGTH=4. A negedge monitor keeps a scoreboard of expected output
// words built from accepted columns and checks stall stability.
//
// Ports: none (top-level bench).
module tb_merge;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int KL = 3;

    logic                   clk;
    logic                   rst;
    logic                   din_valid;
    logic                   din_ready;
    logic [KL-1:0][DW-1:0]  din;
    logic                   dout_valid;
    logic                   dout_ready;
    logic [DW-1:0]          dout;
    logic                   dout_last;
    logic [1:0]             dout_row;
    logic                   full_flag;
    logic                   empty_flag;

    merge #(
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL),
        .KERNEL_LENGTH(KL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .dout_last (dout_last),
        .dout_row  (dout_row),
        .full_flag (full_flag),
        .empty_flag(empty_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard model
    typedef struct {
        logic [DW-1:0] w;
        int            row;
        bit            last;
    } exp_t;

    logic [KL-1:0][DW-1:0] fillq [$];
    exp_t                  expq  [$];

    bit            stall_q = 1'b0;
    logic [DW-1:0] held_dout;
    logic [1:0]    held_row;
    logic          held_last;

    int cyc = 0;
    bit stream_mode = 1'b0;
    int nx = 0;
    int first_cyc = -1;
    int last_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            fillq.delete();
            expq.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check_eq("stall_valid", dout_valid, 1);
                check_eq("stall_dout", dout, held_dout);
                check_eq("stall_row", dout_row, held_row);
                check_eq("stall_last", dout_last, held_last);
            end
            if (dout_valid && dout_ready) begin
                check_eq("sb_pending", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    check_eq("sb_dout", dout, e.w);
                    check_eq("sb_row", dout_row, e.row);
                    check_eq("sb_last", dout_last, e.last);
                end
                if (stream_mode) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    nx++;
                end
            end
            if (din_valid && din_ready) begin
                fillq.push_back(din);
                if (fillq.size() == BL) begin
                    for (int r = 0; r < KL; r++) begin
                        for (int c = 0; c < BL; c++) begin
                            exp_t e;
                            e.w    = fillq[c][r];
                            e.row  = r;
                            e.last = (c == BL - 1);
                            expq.push_back(e);
                        end
                    end
                    fillq.delete();
                end
            end
            stall_q   = dout_valid && !dout_ready;
            held_dout = dout;
            held_row  = dout_row;
            held_last = dout_last;
        end
    end

    // Drives one column (lane k = base + 16*k + j) until accepted; returns the
    // number of rising edges waited, accept edge included.
    task automatic send_col(input int base, input int j, output int waited);
        bit acc;
        din_valid = 1'b1;
        for (int k = 0; k < KL; k++) din[k] = DW'(base + 16 * k + j);
        waited = 0;
        acc = 1'b0;
        for (int t = 0; t < 400; t++) begin
            bit r;
            @(negedge clk);
            r = din_ready;
            @(posedge clk);
            waited++;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        check_eq("send_accept", acc, 1);
        #1 din_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(posedge clk);
            #1;
            if (empty_flag && !dout_valid) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("wait_empty", done, 1);
        check_eq("sb_drained", expq.size(), 0);
    endtask

    int exp_seq [12] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        rst        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout_valid", dout_valid, 0);
        check_eq("rst_din_ready", din_ready, 1);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_dout_row", dout_row, 0);
        check_eq("rst_dout_last", dout_last, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_empty", empty_flag, 1);
        check_eq("rel_full", full_flag, 0);

        // Single bank, no stall
        dout_ready = 1'b1;
        for (int j = 0; j < BL; j++) begin
            send_col(0, j, w);
            check_eq("t2_acc_wait", w, 1);
            if (j == BL - 2) check_eq("t2_no_early_valid", dout_valid, 0);
        end
        check_eq("t2_valid_rise", dout_valid, 1);
        for (int i = 0; i < KL * BL; i++) begin
            check_eq("t2_dout", dout, exp_seq[i]);
            check_eq("t2_row", dout_row, i / BL);
            check_eq("t2_last", dout_last, (i % BL) == BL - 1);
            @(posedge clk);
            #1;
        end
        check_eq("t2_valid_drop", dout_valid, 0);
        check_eq("t2_empty", empty_flag, 1);

        // Backpressure
        dout_ready = 1'b0;
        for (int j = 0; j < 2 * BL; j++) begin
            send_col(100, j, w);
            check_eq("t3_acc_wait", w, 1);
        end
        check_eq("t3_full", full_flag, 1);
        check_eq("t3_din_ready", din_ready, 0);
        din_valid = 1'b1;
        for (int k = 0; k < KL; k++) din[k] = DW'(100 + 16 * k + 8);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("t3_held_ready", din_ready, 0);
        check_eq("t3_held_full", full_flag, 1);
        dout_ready = 1'b1;
        send_col(100, 8, w);
        check_eq("t3_9th_wait", w, KL * BL + 1);
        for (int j = 9; j < 12; j++) send_col(100, j, w);
        wait_empty();

        // Stall stability with pseudo-random dout_ready
        fork
            begin
                for (int j = 0; j < 2 * BL; j++) send_col(400, j, w);
            end
            begin
                for (int t = 0; t < 80; t++) begin
                    @(posedge clk);
                    #1 dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        wait_empty();

        // Streaming, 5 banks
        stream_mode = 1'b1;
        nx = 0;
        first_cyc = -1;
        last_cyc = -1;
        dout_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < BL; j++) send_col(1000 + 100 * b, j, w);
        end
        wait_empty();
        stream_mode = 1'b0;
        check_eq("t5_words", nx, 5 * KL * BL);
        check_eq("t5_span", last_cyc - first_cyc + 1, 5 * KL * BL);

        // Reset mid-drain
        dout_ready = 1'b0;
        for (int j = 0; j < BL; j++) send_col(200, j, w);
        dout_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("t6_rst_valid", dout_valid, 0);
        check_eq("t6_rst_ready", din_ready, 1);
        check_eq("t6_rst_full", full_flag, 0);
        check_eq("t6_rst_dout", dout, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("t6_rel_empty", empty_flag, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("t6_idle_valid", dout_valid, 0);
        end
        for (int j = 0; j < BL; j++) send_col(300, j, w);
        check_eq("t6_new_valid", dout_valid, 1);
        check_eq("t6_new_dout", dout, 300);
        check_eq("t6_new_row", dout_row, 0);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
